// File: rtl/alu_cmd_sequencer.sv
// Purpose : front end for a registered ALU; queues operand/opcode commands, issues one per cycle, returns results in order.
// Latency : command accepted at edge A issues at A+1 and is captured into the result FIFO at A+ALU_LAT+2.
// Backpres: cmd_ready_o drops when the command FIFO is full; issue stalls when results held + in flight reach RES_DEPTH.
//
// Ports:
//   clk, rst_n_i                         clock (rising edge), async active-low reset
//   cmd_valid_i/cmd_ready_o              command handshake, payload cmd_a_i, cmd_b_i, cmd_inst_i
//   alu_a_o, alu_b_o, alu_inst_o         registered operands/opcode to the ALU
//   alu_data_i                           ALU result, sampled ALU_LAT+1 edges after issue
//   res_valid_o/res_ready_i, res_data_o  show-ahead result handshake
//   busy_o                               any command queued, in flight or result pending

// Generic synchronous FIFO with show-ahead head.
// Latency : pushed data visible at head one edge after push when empty.
// Backpres: push ignored while full, pop ignored while empty (full/empty judged at start of cycle).
module alu_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [W-1:0]               head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Head reads as zero when empty so the output is clean after reset.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly AW bits, so DEPTH being a power of 2 makes them wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_cmd_sequencer #(
    parameter int         ALU_LAT   = 1,
    parameter int         CMD_DEPTH = 4,
    parameter int         RES_DEPTH = 4,
    parameter logic [2:0] IDLE_INST = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_a_i,
    input  logic [7:0]  cmd_b_i,
    input  logic [2:0]  cmd_inst_i,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [2:0]  alu_inst_o,
    input  logic [15:0] alu_data_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [15:0] res_data_o,
    output logic        busy_o
);
    localparam int CMD_W  = 19;
    localparam int CCW    = $clog2(CMD_DEPTH) + 1;
    localparam int RCW    = $clog2(RES_DEPTH) + 1;
    localparam int IW     = $clog2(ALU_LAT + 2);
    localparam int SW     = $clog2(RES_DEPTH + ALU_LAT + 2) + 1;

    logic [CMD_W-1:0] cmd_head;
    logic [CCW-1:0]   cmd_count;
    logic [RCW-1:0]   res_count;
    logic             cmd_full;
    logic             cmd_empty;
    logic             issue;
    logic             capture;
    logic [ALU_LAT:0] pipe;
    logic [IW-1:0]    inflight;
    logic [SW-1:0]    credit_sum;

    assign cmd_full    = (cmd_count == CCW'(CMD_DEPTH));
    assign cmd_empty   = (cmd_count == '0);
    assign cmd_ready_o = ~cmd_full;

    alu_seq_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .rst_n    (rst_n_i),
        .push     (cmd_valid_i),
        .push_dat ({cmd_a_i, cmd_b_i, cmd_inst_i}),
        .pop      (issue),
        .head_dat (cmd_head),
        .count    (cmd_count)
    );

    // Number of issued commands whose result has not yet been captured.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + IW'(pipe[i]);
        end
    end

    // Credit: every issued command reserves a result slot, so capture can never overflow.
    // The entry being captured this edge still counts as in flight, keeping the check conservative.
    assign credit_sum = SW'(res_count) + SW'(inflight);
    assign issue      = ~cmd_empty & (credit_sum < SW'(RES_DEPTH));

    // pipe[k] set means the command issued k+1 edges ago; the ALU result is valid when it reaches the top.
    assign capture = pipe[ALU_LAT];

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe       <= '0;
            alu_a_o    <= '0;
            alu_b_o    <= '0;
            alu_inst_o <= IDLE_INST;
        end else begin
            pipe <= {pipe[ALU_LAT-1:0], issue};
            if (issue) begin
                alu_a_o    <= cmd_head[18:11];
                alu_b_o    <= cmd_head[10:3];
                alu_inst_o <= cmd_head[2:0];
            end else begin
                alu_a_o    <= '0;
                alu_b_o    <= '0;
                alu_inst_o <= IDLE_INST;
            end
        end
    end

    alu_seq_fifo #(.W(16), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk      (clk),
        .rst_n    (rst_n_i),
        .push     (capture),
        .push_dat (alu_data_i),
        .pop      (res_ready_i),
        .head_dat (res_data_o),
        .count    (res_count)
    );

    assign res_valid_o = (res_count != '0);
    assign busy_o      = ~cmd_empty | (pipe != '0) | res_valid_o;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Purpose : directed bench for alu_cmd_sequencer with a 1-cycle registered ALU stub (data = {a,b}).
// Latency : stimulus driven 1 time unit after each rising edge, outputs sampled there too.
// Backpres: res_ready driven per step; a negedge monitor records every accepted result.
module tb_alu_cmd_sequencer;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_inst;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_inst;
    logic [15:0] alu_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [15:0] got_q[$];

    alu_cmd_sequencer dut (
        .clk         (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_a_i     (cmd_a),
        .cmd_b_i     (cmd_b),
        .cmd_inst_i  (cmd_inst),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_inst_o  (alu_inst),
        .alu_data_i  (alu_data),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_data_o  (res_data),
        .busy_o      (busy)
    );

    // ALU stub: one registered stage, result = {a, b}.
    always_ff @(posedge clk) alu_data <= {alu_a, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record results as they are handed over (stable mid-cycle).
    always @(negedge clk) begin
        if (res_valid && res_ready) got_q.push_back(res_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] inst);
        logic done;
        done      = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_inst  = inst;
        cmd_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            if (cmd_ready) done = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        chk("push_accept", 32'(done), 32'd1);
    endtask

    logic [7:0]  a4 [4];
    logic [7:0]  b4 [4];
    logic [15:0] e4 [4];

    initial begin
        int base;
        int n;
        a4 = '{8'd37, 8'd50, 8'd65, 8'd1};
        b4 = '{8'd128, 8'd60, 8'd100, 8'd2};
        e4 = '{16'h2580, 16'h323C, 16'h4164, 16'h0102};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_inst  = '0;
        res_ready = 1'b0;

        // Reset values.
        #12;
        chk("rst_alu_inst", 32'(alu_inst), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single command, exact latency.
        cmd_a = 8'd25; cmd_b = 8'd35; cmd_inst = 3'b011; cmd_valid = 1'b1;
        tick();                                      // edge A: accepted
        cmd_valid = 1'b0;
        chk("single_busy", 32'(busy), 32'd1);
        tick();                                      // A+1: issued
        chk("single_alu_a", 32'(alu_a), 32'd25);
        chk("single_alu_b", 32'(alu_b), 32'd35);
        chk("single_alu_inst", 32'(alu_inst), 32'd3);
        chk("single_res_early", 32'(res_valid), 32'd0);
        tick();                                      // A+2: ALU output valid, driver idle
        chk("single_idle_inst", 32'(alu_inst), 32'd0);
        chk("single_idle_a", 32'(alu_a), 32'd0);
        chk("single_res_notyet", 32'(res_valid), 32'd0);
        tick();                                      // A+3: captured
        chk("single_res_valid", 32'(res_valid), 32'd1);
        chk("single_res_data", 32'(res_data), 32'h1923);
        res_ready = 1'b1;
        tick();
        chk("single_popped", 32'(res_valid), 32'd0);
        chk("single_busy_end", 32'(busy), 32'd0);

        // Four back-to-back commands, full throughput.
        for (int k = 0; k < 7; k++) begin
            if (k < 4) begin
                cmd_a = a4[k]; cmd_b = b4[k]; cmd_inst = 3'(k); cmd_valid = 1'b1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (k >= 1 && k <= 4) chk($sformatf("b2b_issue%0d", k - 1), 32'(alu_a), 32'(a4[k-1]));
            if (k >= 3) begin
                chk($sformatf("b2b_valid%0d", k - 3), 32'(res_valid), 32'd1);
                chk($sformatf("b2b_data%0d", k - 3), 32'(res_data), 32'(e4[k-3]));
            end
        end
        tick();
        chk("b2b_drained", 32'(busy), 32'd0);

        // Backpressure: results held, issue stalls, command FIFO fills.
        res_ready = 1'b0;
        base = got_q.size();
        for (int i = 0; i < 8; i++) push_cmd(8'h10 + 8'(i), 8'hA0 + 8'(i), 3'(i));
        repeat (3) tick();
        chk("bp_cmd_full", 32'(cmd_ready), 32'd0);
        chk("bp_res_valid", 32'(res_valid), 32'd1);
        chk("bp_res_head", 32'(res_data), 32'h10A0);
        chk("bp_stall_idle", 32'(alu_inst), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);

        // Refused push while full, including the edge where an issue frees a slot.
        cmd_a = 8'hEE; cmd_b = 8'hEE; cmd_inst = 3'b111; cmd_valid = 1'b1;
        res_ready = 1'b1;
        tick();                                      // result popped, nothing issued yet
        chk("full_still_full", 32'(cmd_ready), 32'd0);
        tick();                                      // issue pops cmd; push refused
        cmd_valid = 1'b0;
        chk("full_slot_freed", 32'(cmd_ready), 32'd1);
        push_cmd(8'h18, 8'hA8, 3'd0);
        push_cmd(8'h19, 8'hA9, 3'd1);
        n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        chk("bp_drain_idle", 32'(busy), 32'd0);
        chk("bp_result_count", 32'(got_q.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            logic [15:0] want;
            logic [15:0] seen;
            want = {8'h10 + 8'(i), 8'hA0 + 8'(i)};
            seen = (base + i < got_q.size()) ? got_q[base + i] : 16'hxxxx;
            chk($sformatf("bp_order%0d", i), 32'(seen), 32'(want));
        end

        // Reset mid-stream with two commands in flight.
        cmd_a = 8'h55; cmd_b = 8'h66; cmd_inst = 3'd2; cmd_valid = 1'b1;
        tick();
        cmd_a = 8'h77; cmd_b = 8'h88; cmd_inst = 3'd4;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_inst", 32'(alu_inst), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        #12 rst_n = 1'b1;
        tick();
        base = got_q.size();
        repeat (6) tick();
        chk("post_rst_no_stale", 32'(got_q.size() - base), 32'd0);
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Normal operation resumes after reset.
        base = got_q.size();
        push_cmd(8'h3C, 8'h5A, 3'd5);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_count", 32'(got_q.size() - base), 32'd1);
        chk("post_rst_data", 32'((got_q.size() > base) ? got_q[base] : 16'hxxxx), 32'h3C5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
